// File: rtl/count_mod_buffer.sv
// count_mod_buffer: FIFO of counter samples, each tagged with sample % MOD_DIV.
// Optional macro DROP_COUNT_EN adds a saturating count of rejected samples.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid, in_data   sample offered by the counter
//   in_ready            buffer has room this cycle
//   out_valid           head entry available
//   out_data, out_rem   head sample and its remainder (0 when empty)
//   out_ready           consumer takes the head entry this cycle
//   level               number of stored entries
//   drop_count          rejected samples, saturating (DROP_COUNT_EN only)
module count_mod_buffer #(
    parameter int DEPTH   = 8,
    parameter int MOD_DIV = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [3:0]                 in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [3:0]                 out_data,
    output logic [3:0]                 out_rem,
    input  logic                       out_ready,
`ifdef DROP_COUNT_EN
    output logic [7:0]                 drop_count,
`endif
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [3:0] DIV = 4'(MOD_DIV);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [3:0]    rem;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    // Flags come straight from the registered level, so a pop in a full
    // cycle cannot open the input until the following cycle.
    assign in_ready  = (level != FULL);
    assign out_valid = (level != '0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign rem = in_data % DIV;

    assign head     = mem[rd_ptr];
    assign out_data = out_valid ? head[7:4] : 4'd0;
    assign out_rem  = out_valid ? head[3:0] : 4'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    // Storage is not reset; empty-forcing on the outputs hides stale words.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= {in_data, rem};
        end
    end

`ifdef DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= 8'd0;
        end else if (in_valid && !in_ready && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_count_mod_buffer.sv
// tb_count_mod_buffer: directed checks of count_mod_buffer (DEPTH=8, MOD_DIV=3).
// Builds with or without DROP_COUNT_EN.
module tb_count_mod_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [3:0] out_rem;
    logic       out_ready;
    logic [3:0] level;
`ifdef DROP_COUNT_EN
    logic [7:0] drop_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    count_mod_buffer #(.DEPTH(8), .MOD_DIV(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_rem    (out_rem),
        .out_ready  (out_ready),
`ifdef DROP_COUNT_EN
        .drop_count (drop_count),
`endif
        .level      (level)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 4'd5; out_ready = 1'b0;
        step();
        step();
        reset = 1'b0; in_valid = 1'b0;
        tests++;
        if (level !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_data !== 4'd0 || out_rem !== 4'd0) begin
            fails++;
            $display("FAIL reset: level=%0d ov=%b ir=%b od=%0d or=%0d want 0 0 1 0 0",
                     level, out_valid, in_ready, out_data, out_rem);
        end
`ifdef DROP_COUNT_EN
        tests++;
        if (drop_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_drop: got %0d want 0", drop_count);
        end
`endif
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 4'd7;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 4'd0) begin
            fails++;
            $display("FAIL no_bypass: ov=%b od=%0d want 0 0", out_valid, out_data);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 4'd7 || out_rem !== 4'd1 ||
            level !== 4'd1) begin
            fails++;
            $display("FAIL single_push: ov=%b od=%0d or=%0d lvl=%0d want 1 7 1 1",
                     out_valid, out_data, out_rem, level);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests++;
        if (level !== 4'd0 || out_valid !== 1'b0 || out_data !== 4'd0) begin
            fails++;
            $display("FAIL single_pop: lvl=%0d ov=%b od=%0d want 0 0 0",
                     level, out_valid, out_data);
        end
    endtask

    task automatic test_fill_wrap();
        logic [3:0] exp_rem [8] = '{4'd0, 4'd1, 4'd2, 4'd0,
                                    4'd1, 4'd2, 4'd0, 4'd1};
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 4'(i);
            step();
            if (i == 7) begin
                tests++;
                if (in_ready !== 1'b0 || level !== 4'd8) begin
                    fails++;
                    $display("FAIL fill_full: ir=%b lvl=%0d want 0 8", in_ready, level);
                end
            end
        end
        in_valid = 1'b0;
        tests++;
        if (level !== 4'd8) begin
            fails++;
            $display("FAIL fill_drop_level: got %0d want 8", level);
        end
`ifdef DROP_COUNT_EN
        tests++;
        if (drop_count !== 8'd2) begin
            fails++;
            $display("FAIL fill_drop_count: got %0d want 2", drop_count);
        end
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== 4'(i) || out_rem !== exp_rem[i]) begin
                fails++;
                $display("FAIL drain[%0d]: ov=%b od=%0d or=%0d want 1 %0d %0d",
                         i, out_valid, out_data, out_rem, i, exp_rem[i]);
            end
            step();
        end
        out_ready = 1'b0;
        tests++;
        if (level !== 4'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty: lvl=%0d ov=%b want 0 0", level, out_valid);
        end
    endtask

    // Refill through the pointer wrap, then pop and offer a sample while full.
    task automatic test_full_simul();
        for (int i = 8; i < 16; i++) begin
            in_valid = 1'b1; in_data = 4'(i);
            step();
        end
        in_data = 4'd0; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        tests++;
        if (level !== 4'd7 || in_ready !== 1'b1 || out_data !== 4'd9) begin
            fails++;
            $display("FAIL full_simul: lvl=%0d ir=%b od=%0d want 7 1 9",
                     level, in_ready, out_data);
        end
`ifdef DROP_COUNT_EN
        tests++;
        if (drop_count !== 8'd3) begin
            fails++;
            $display("FAIL full_simul_drop: got %0d want 3", drop_count);
        end
`endif
        out_ready = 1'b1;
        for (int i = 9; i < 16; i++) begin
            tests++;
            if (out_data !== 4'(i) || out_rem !== 4'(i % 3)) begin
                fails++;
                $display("FAIL wrap_drain[%0d]: od=%0d or=%0d want %0d %0d",
                         i, out_data, out_rem, i, i % 3);
            end
            step();
        end
        out_ready = 1'b0;
        tests++;
        if (level !== 4'd0) begin
            fails++;
            $display("FAIL wrap_drain_empty: lvl=%0d want 0", level);
        end
    endtask

    task automatic test_streaming();
        logic [3:0] exp;
        in_valid = 1'b1; in_data = 4'd15;
        step();
        for (int k = 0; k < 20; k++) begin
            in_data = 4'(14 - k); out_ready = 1'b1;
            step();
            exp = 4'(14 - k);
            tests++;
            if (level !== 4'd1 || out_data !== exp || out_rem !== 4'(exp % 3)) begin
                fails++;
                $display("FAIL stream[%0d]: lvl=%0d od=%0d or=%0d want 1 %0d %0d",
                         k, level, out_data, out_rem, exp, exp % 3);
            end
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        tests++;
        if (level !== 4'd0) begin
            fails++;
            $display("FAIL stream_end: lvl=%0d want 0", level);
        end
`ifdef DROP_COUNT_EN
        tests++;
        if (drop_count !== 8'd3) begin
            fails++;
            $display("FAIL stream_drop: got %0d want 3", drop_count);
        end
`endif
    endtask

    task automatic test_empty_push_pop();
        in_valid = 1'b1; in_data = 4'd4; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        tests++;
        if (level !== 4'd1 || out_data !== 4'd4 || out_rem !== 4'd1) begin
            fails++;
            $display("FAIL empty_push_pop: lvl=%0d od=%0d or=%0d want 1 4 1",
                     level, out_data, out_rem);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 4'(i + 1);
            step();
        end
        in_valid = 1'b0;
        tests++;
        if (level !== 4'd5) begin
            fails++;
            $display("FAIL mid_level: got %0d want 5", level);
        end
        reset = 1'b1; in_valid = 1'b1; in_data = 4'd2; out_ready = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tests++;
        if (level !== 4'd0 || out_valid !== 1'b0 || out_data !== 4'd0) begin
            fails++;
            $display("FAIL mid_reset: lvl=%0d ov=%b od=%0d want 0 0 0",
                     level, out_valid, out_data);
        end
`ifdef DROP_COUNT_EN
        tests++;
        if (drop_count !== 8'd0) begin
            fails++;
            $display("FAIL mid_reset_drop: got %0d want 0", drop_count);
        end
`endif
        in_valid = 1'b1; in_data = 4'd11;
        step();
        in_valid = 1'b0;
        tests++;
        if (level !== 4'd1 || out_data !== 4'd11 || out_rem !== 4'd2) begin
            fails++;
            $display("FAIL mid_after: lvl=%0d od=%0d or=%0d want 1 11 2",
                     level, out_data, out_rem);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_fill_wrap();
        test_full_simul();
        test_streaming();
        test_empty_push_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
